// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - write-drain store buffer between MEM stage and data memory
// FIFO of committed stores drained over req/ack, with youngest-match load forwarding.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stop,
    input  logic             in_is_write,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_data,
    input  logic [31:0]      rd_addr,
    output logic             rd_hit,
    output logic [31:0]      rd_data,
    output logic             stall,
    output logic             bus_req,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wdata,
    input  logic             bus_ack,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, push, pop;
    logic             unused_lsbs;

    assign unused_lsbs = ^{in_addr[1:0], rd_addr[1:0]};

    assign full  = (count_q == CNT_W'(DEPTH));
    assign push  = in_is_write & ~stop & ~full;
    assign pop   = bus_req & bus_ack;
    assign stall = in_is_write & full;
    assign count = count_q;
    assign empty = (count_q == '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Entries are cleared on reset so the bus and forwarding outputs start at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= in_addr[31:2];
                data_q[wr_ptr_q] <= in_data;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // On ack, count_d already equals count-1+push, so it decides back-to-back vs. idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = REQ;
            REQ:     if (bus_ack && count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req   = (state_q == REQ);
        bus_addr  = {addr_q[rd_ptr_q], 2'b00};
        bus_wdata = data_q[rd_ptr_q];
    end

    // Walk oldest to youngest so the last match (closest to wr_ptr) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr_q[idx] == rd_addr[31:2])) begin
                rd_hit  = 1'b1;
                rd_data = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
// Queue-based reference model; directed scenarios followed by random traffic.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stop;
    logic             in_is_write;
    logic [31:0]      in_addr;
    logic [31:0]      in_data;
    logic [31:0]      rd_addr;
    logic             rd_hit;
    logic [31:0]      rd_data;
    logic             stall;
    logic             bus_req;
    logic [31:0]      bus_addr;
    logic [31:0]      bus_wdata;
    logic             bus_ack;
    logic [CNT_W-1:0] count;
    logic             empty;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stop(stop), .in_is_write(in_is_write),
        .in_addr(in_addr), .in_data(in_data), .rd_addr(rd_addr),
        .rd_hit(rd_hit), .rd_data(rd_data), .stall(stall),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .count(count), .empty(empty)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    bit   m_req;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic        hit;
        logic [31:0] fwd;
        hit = 1'b0;
        fwd = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].a[31:2] == rd_addr[31:2]) begin
                hit = 1'b1;
                fwd = q[i].d;
            end
        end
        chk("count",   32'(count),   32'(q.size()));
        chk("empty",   32'(empty),   32'(q.size() == 0));
        chk("stall",   32'(stall),   32'(in_is_write && q.size() == DEPTH));
        chk("bus_req", 32'(bus_req), 32'(m_req));
        if (m_req && q.size() > 0) begin
            chk("bus_addr",  bus_addr,  {q[0].a[31:2], 2'b00});
            chk("bus_wdata", bus_wdata, q[0].d);
        end
        chk("rd_hit",  32'(rd_hit), 32'(hit));
        chk("rd_data", rd_data, fwd);
    endtask

    task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input bit ack, input bit stp, input logic [31:0] ra);
        in_is_write = w;
        in_addr     = a;
        in_data     = d;
        bus_ack     = ack;
        stop        = stp;
        rd_addr     = ra;
    endtask

    // Checks outputs for the current inputs, then advances model and DUT by one edge.
    task automatic cycle();
        bit push, pop;
        int sz;
        #1;
        check_outputs();
        sz   = q.size();
        push = in_is_write && !stop && (sz < DEPTH);
        pop  = m_req && bus_ack;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{in_addr, in_data});
        if (pop) m_req = (q.size() != 0);
        else if (!m_req) m_req = (sz != 0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h100);
        m_req = 0;
        #12;
        chk("rst_bus_addr",  bus_addr,  32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_req",   32'(bus_req), 32'h0);
        chk("rst_rd_hit",    32'(rd_hit),  32'h0);
        chk("rst_count",     32'(count),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // 1: single store, one-cycle request latency, single ack
        drive(1, 32'h100, 32'hAABBCCDD, 0, 0, 32'h100);
        cycle();
        drive(0, 0, 0, 0, 0, 32'h100);
        #1;
        chk("t1_count1", 32'(count), 32'd1);
        chk("t1_req_lat0", 32'(bus_req), 32'd0);
        cycle();
        chk("t1_req_lat1", 32'(bus_req), 32'd1);
        chk("t1_bus_addr", bus_addr, 32'h100);
        drive(0, 0, 0, 1, 0, 32'h100);
        cycle();
        drive(0, 0, 0, 0, 0, 32'h100);
        cycle();

        // 2: back-to-back drain with ack held high
        drive(1, 32'h200, 32'h1, 1, 0, 32'h204);
        cycle();
        drive(1, 32'h204, 32'h2, 1, 0, 32'h204);
        cycle();
        drive(1, 32'h208, 32'h3, 1, 0, 32'h204);
        cycle();
        drive(0, 0, 0, 1, 0, 32'h208);
        for (int i = 0; i < 5; i++) cycle();

        // 3: fill, stall, ack+push while full refused, then accepted
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h600 + 32'(4 * i), 32'h60 + 32'(i), 0, 0, 32'h604);
            cycle();
        end
        drive(1, 32'h700, 32'h70, 0, 0, 32'h700);
        #1;
        chk("t3_stall", 32'(stall), 32'd1);
        cycle();
        chk("t3_count_full", 32'(count), 32'd4);
        drive(1, 32'h700, 32'h70, 1, 0, 32'h700);
        cycle();
        chk("t3_refused", 32'(count), 32'd3);
        drive(1, 32'h700, 32'h70, 0, 0, 32'h700);
        cycle();
        chk("t3_accepted", 32'(count), 32'd4);
        drive(0, 0, 0, 1, 0, 32'h700);
        for (int i = 0; i < 6; i++) cycle();

        // 4: duplicate address forwarding, youngest wins
        drive(1, 32'h300, 32'h11, 0, 0, 32'h302);
        cycle();
        drive(1, 32'h300, 32'h22, 0, 0, 32'h302);
        cycle();
        drive(0, 0, 0, 0, 0, 32'h302);
        #1;
        chk("t4_hit", 32'(rd_hit), 32'd1);
        chk("t4_data", rd_data, 32'h22);
        cycle();
        drive(0, 0, 0, 0, 0, 32'h304);
        #1;
        chk("t4_miss_hit", 32'(rd_hit), 32'd0);
        chk("t4_miss_data", rd_data, 32'h0);
        cycle();

        // 5: stop blocks capture, drain continues
        drive(1, 32'h500, 32'h55, 1, 1, 32'h300);
        for (int i = 0; i < 4; i++) cycle();
        chk("t5_drained", 32'(count), 32'd0);

        // 6: async reset mid-request discards pending stores
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h800 + 32'(4 * i), 32'h80 + 32'(i), 0, 0, 32'h800);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 32'h800);
        cycle();
        chk("t6_req_before", 32'(bus_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req_async", 32'(bus_req), 32'd0);
        chk("t6_count_async", 32'(count), 32'd0);
        chk("t6_hit_async", 32'(rd_hit), 32'd0);
        q.delete();
        m_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 0, 32'h800);
        for (int i = 0; i < 4; i++) cycle();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 55,
                  32'h400 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3)),
                  $urandom,
                  $urandom_range(0, 99) < 40,
                  $urandom_range(0, 99) < 15,
                  32'h400 + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3)));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
